keystone_coeff_sequencer: RTL and testbench

// Control/sequencing block in front of Keystone_Correction.
// - Double-buffers the 8 homography coefficients (H11..H32): software writes a shadow bank; the

---
 rtl/keystone_coeff_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_keystone_coeff_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keystone_coeff_sequencer.sv
// keystone_coeff_sequencer
// Control block in front of the keystone correction core.
//  - Holds a shadow and an active bank of the 8 homography coefficients.
//    Software writes the shadow bank. The core only ever sees the active bank.
//  - Copies shadow->active at a frame boundary. When that happens while
//    streaming, it inserts a one-cycle stall so the start-of-frame beat
//    reaches the core after the new set is in place.
//  - Enables and disables the core on frame boundaries.
//  - Stretches a software reset pulse to RST_CYCLES cycles.
// Ports
//  clock, reset          sole clock; synchronous active-high reset
//  cfg_wr_en/addr/data   shadow bank write (addr 0..7 = H11,H12,H13,H21,H22,H23,H31,H32)
//  cfg_commit            pulse: shadow bank ready for swap
//  enable_req            level: correction wanted
//  sw_reset_req          pulse: restart core
//  vid_tvalid/tuser      upstream stream handshake (tuser = SOF)
//  vid_tready            to upstream = core_tready & ~stall
//  core_tvalid           to core     = vid_tvalid & ~stall
//  core_tready           ready from core
//  core_clock_en         core clock enable
//  core_reset            core reset
//  h11..h32              active coefficients (registered)
//  commit_pend           a commit is waiting for a frame boundary
//  running               core is in RUN or DRAIN
//  frame_cnt             SOF beats accepted while running, wraps
module keystone_coeff_sequencer #(
    parameter int DATA_W     = 32,
    parameter int RST_CYCLES = 16,
    parameter int FCNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_wr_en,
    input  logic [2:0]        cfg_wr_addr,
    input  logic [DATA_W-1:0] cfg_wr_data,
    input  logic              cfg_commit,
    input  logic              enable_req,
    input  logic              sw_reset_req,
    input  logic              vid_tvalid,
    input  logic              vid_tuser,
    output logic              vid_tready,
    output logic              core_tvalid,
    input  logic              core_tready,
    output logic              core_clock_en,
    output logic              core_reset,
    output logic [DATA_W-1:0] h11,
    output logic [DATA_W-1:0] h12,
    output logic [DATA_W-1:0] h13,
    output logic [DATA_W-1:0] h21,
    output logic [DATA_W-1:0] h22,
    output logic [DATA_W-1:0] h23,
    output logic [DATA_W-1:0] h31,
    output logic [DATA_W-1:0] h32,
    output logic              commit_pend,
    output logic              running,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int CNT_W = $clog2(RST_CYCLES + 1);
    // 1.0 in Q16.16: the diagonal entries of the identity homography
    localparam logic [DATA_W-1:0] ONE_Q16 = DATA_W'(32'h0001_0000);

    typedef enum logic [2:0] {
        ST_RSTH  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ARMED = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic              stall_reg, stall_next;
    logic              swap;
    logic              commit_pend_reg;
    logic [CNT_W-1:0]  hold_cnt_reg;
    logic [FCNT_W-1:0] frame_cnt_reg;
    logic              sof_pres;
    logic              sof_acc;
    logic              active_run;

    assign sof_pres    = vid_tvalid & vid_tuser;
    assign vid_tready  = core_tready & ~stall_reg;
    assign core_tvalid = vid_tvalid & ~stall_reg;
    assign sof_acc     = sof_pres & vid_tready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_RSTH;
            stall_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            stall_reg <= stall_next;
        end
    end

    // Next-state logic. The stall is a single-cycle pulse, so it defaults low.
    always_comb begin
        state_next = state_reg;
        stall_next = 1'b0;
        swap       = 1'b0;
        case (state_reg)
            ST_RSTH: begin
                if (hold_cnt_reg <= CNT_W'(1)) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                // Core is stopped: a pending set can go live without a bubble
                swap = commit_pend_reg;
                if (enable_req) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable_req) begin
                    state_next = ST_IDLE;
                end else if (sof_pres && !stall_reg) begin
                    swap       = commit_pend_reg;
                    stall_next = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (commit_pend_reg && sof_pres && !stall_reg) begin
                    swap       = 1'b1;
                    stall_next = 1'b1;
                end
                if (!enable_req) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable_req) begin
                    state_next = ST_RUN;
                end else if (sof_pres && !stall_reg) begin
                    stall_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_RSTH;
        endcase
        // Software reset beats every other event in the same cycle
        if (sw_reset_req) begin
            state_next = ST_RSTH;
            stall_next = 1'b0;
            swap       = 1'b0;
        end
    end

    // Output logic
    always_comb begin
        core_reset    = (state_reg == ST_RSTH);
        active_run    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
        core_clock_en = active_run;
        running       = active_run;
    end

    // Reset stretch counter, commit flag and frame counter
    always_ff @(posedge clock) begin
        if (reset || sw_reset_req) begin
            hold_cnt_reg    <= CNT_W'(RST_CYCLES);
            commit_pend_reg <= 1'b0;
            frame_cnt_reg   <= '0;
        end else begin
            if (state_reg == ST_RSTH && hold_cnt_reg > CNT_W'(1))
                hold_cnt_reg <= hold_cnt_reg - CNT_W'(1);
            // A commit arriving on the swap edge re-arms for the next frame
            commit_pend_reg <= (commit_pend_reg & ~swap) | cfg_commit;
            if (sof_acc && active_run)
                frame_cnt_reg <= frame_cnt_reg + FCNT_W'(1);
        end
    end

    assign commit_pend = commit_pend_reg;
    assign frame_cnt   = frame_cnt_reg;

    // Coefficient banks, one shadow/active pair per entry
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bank
            localparam logic [DATA_W-1:0] INIT_VAL = (gi == 0 || gi == 4) ? ONE_Q16 : '0;
            logic [DATA_W-1:0] shadow_reg;
            logic [DATA_W-1:0] active_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    shadow_reg <= INIT_VAL;
                    active_reg <= INIT_VAL;
                end else begin
                    if (cfg_wr_en && !sw_reset_req && cfg_wr_addr == 3'(gi))
                        shadow_reg <= cfg_wr_data;
                    // Swap copies the shadow value from before this edge's write
                    if (swap)
                        active_reg <= shadow_reg;
                end
            end
        end
    endgenerate

    assign h11 = g_bank[0].active_reg;
    assign h12 = g_bank[1].active_reg;
    assign h13 = g_bank[2].active_reg;
    assign h21 = g_bank[3].active_reg;
    assign h22 = g_bank[4].active_reg;
    assign h23 = g_bank[5].active_reg;
    assign h31 = g_bank[6].active_reg;
    assign h32 = g_bank[7].active_reg;

endmodule

// File: tb/tb_keystone_coeff_sequencer.sv
module tb_keystone_coeff_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_wr_en;
    logic [2:0]  cfg_wr_addr;
    logic [31:0] cfg_wr_data;
    logic        cfg_commit;
    logic        enable_req;
    logic        sw_reset_req;
    logic        vid_tvalid;
    logic        vid_tuser;
    logic        vid_tready;
    logic        core_tvalid;
    logic        core_tready;
    logic        core_clock_en;
    logic        core_reset;
    logic [31:0] h11, h12, h13, h21, h22, h23, h31, h32;
    logic        commit_pend;
    logic        running;
    logic [15:0] frame_cnt;

    keystone_coeff_sequencer #(
        .DATA_W    (32),
        .RST_CYCLES(16),
        .FCNT_W    (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_commit   (cfg_commit),
        .enable_req   (enable_req),
        .sw_reset_req (sw_reset_req),
        .vid_tvalid   (vid_tvalid),
        .vid_tuser    (vid_tuser),
        .vid_tready   (vid_tready),
        .core_tvalid  (core_tvalid),
        .core_tready  (core_tready),
        .core_clock_en(core_clock_en),
        .core_reset   (core_reset),
        .h11          (h11),
        .h12          (h12),
        .h13          (h13),
        .h21          (h21),
        .h22          (h22),
        .h23          (h23),
        .h31          (h31),
        .h32          (h32),
        .commit_pend  (commit_pend),
        .running      (running),
        .frame_cnt    (frame_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr_en;
        logic [2:0]  addr;
        logic [31:0] data;
        logic        commit;
        logic        en;
        logic        tvalid;
        logic        tuser;
        logic        ctready;
        logic        x_tready;   // before the edge
        logic        x_ctvalid;  // before the edge
        logic        x_pend;     // after the edge
        logic        x_run;      // after the edge (running and core_clock_en)
        logic [15:0] x_fcnt;     // after the edge
        logic [2:0]  x_hidx;     // coefficient checked after the edge
        logic [31:0] x_hval;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_h(input logic [2:0] idx);
        case (idx)
            3'd0: get_h = h11;
            3'd1: get_h = h12;
            3'd2: get_h = h13;
            3'd3: get_h = h21;
            3'd4: get_h = h22;
            3'd5: get_h = h23;
            3'd6: get_h = h31;
            default: get_h = h32;
        endcase
    endfunction

    task automatic add(input logic wr, input logic [2:0] a, input logic [31:0] d,
                       input logic cm, input logic en, input logic tv, input logic tu,
                       input logic cr, input logic xtr, input logic xcv, input logic xp,
                       input logic xr, input logic [15:0] xf, input logic [2:0] xi,
                       input logic [31:0] xv);
        vec_t v;
        v.wr_en = wr; v.addr = a; v.data = d; v.commit = cm; v.en = en;
        v.tvalid = tv; v.tuser = tu; v.ctready = cr;
        v.x_tready = xtr; v.x_ctvalid = xcv; v.x_pend = xp; v.x_run = xr;
        v.x_fcnt = xf; v.x_hidx = xi; v.x_hval = xv;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_wr_en = 0; cfg_wr_addr = 0; cfg_wr_data = 0; cfg_commit = 0;
        sw_reset_req = 0; vid_tvalid = 0; vid_tuser = 0;
    endtask

    // Count cycles core_reset stays high, bounded
    task automatic count_reset_hold(input string name);
        int n = 0;
        while (core_reset === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(name, 64'(n), 64'(16));
        $display("%s: core_reset held %0d cycles", name, n);
    endtask

    initial begin
        reset = 1; enable_req = 0; core_tready = 1;
        idle_inputs();

        // Wr addr data commit en tv tu ctr | tready ctvalid | pend run fcnt hidx hval
        add(1, 3'd2, 32'h0005_0000, 1, 0, 0, 0, 1, 1, 0, 1, 0, 16'd0, 3'd2, 32'h0);
        add(0, 3'd0, 32'h0,         0, 0, 0, 0, 1, 1, 0, 0, 0, 16'd0, 3'd2, 32'h0005_0000);
        add(0, 3'd0, 32'h0,         0, 1, 0, 0, 1, 1, 0, 0, 0, 16'd0, 3'd0, 32'h0001_0000);
        add(0, 3'd0, 32'h0,         0, 1, 1, 1, 0, 0, 1, 0, 1, 16'd0, 3'd4, 32'h0001_0000);
        add(0, 3'd0, 32'h0,         0, 1, 1, 1, 1, 0, 0, 0, 1, 16'd0, 3'd2, 32'h0005_0000);
        add(0, 3'd0, 32'h0,         0, 1, 1, 1, 1, 1, 1, 0, 1, 16'd1, 3'd2, 32'h0005_0000);
        add(0, 3'd0, 32'h0,         0, 1, 1, 0, 1, 1, 1, 0, 1, 16'd1, 3'd6, 32'h0);
        add(1, 3'd6, 32'hFFFF_0001, 1, 1, 0, 0, 1, 1, 0, 1, 1, 16'd1, 3'd6, 32'h0);
        add(0, 3'd0, 32'h0,         0, 1, 1, 1, 1, 1, 1, 0, 1, 16'd2, 3'd6, 32'hFFFF_0001);
        add(0, 3'd0, 32'h0,         0, 1, 1, 1, 1, 0, 0, 0, 1, 16'd2, 3'd6, 32'hFFFF_0001);
        add(0, 3'd0, 32'h0,         0, 1, 1, 0, 1, 1, 1, 0, 1, 16'd2, 3'd6, 32'hFFFF_0001);
        add(1, 3'd1, 32'h0000_0123, 0, 1, 0, 0, 1, 1, 0, 0, 1, 16'd2, 3'd1, 32'h0);
        add(0, 3'd0, 32'h0,         1, 1, 1, 1, 1, 1, 1, 1, 1, 16'd3, 3'd1, 32'h0);
        add(0, 3'd0, 32'h0,         0, 1, 1, 0, 1, 1, 1, 1, 1, 16'd3, 3'd1, 32'h0);
        add(0, 3'd0, 32'h0,         0, 1, 1, 1, 1, 1, 1, 0, 1, 16'd4, 3'd1, 32'h0000_0123);
        add(0, 3'd0, 32'h0,         0, 1, 0, 0, 1, 0, 0, 0, 1, 16'd4, 3'd1, 32'h0000_0123);
        add(0, 3'd0, 32'h0,         0, 0, 1, 0, 1, 1, 1, 0, 1, 16'd4, 3'd0, 32'h0001_0000);
        add(0, 3'd0, 32'h0,         0, 0, 1, 0, 1, 1, 1, 0, 1, 16'd4, 3'd3, 32'h0);
        add(0, 3'd0, 32'h0,         0, 0, 1, 1, 1, 1, 1, 0, 0, 16'd5, 3'd7, 32'h0);
        add(0, 3'd0, 32'h0,         0, 0, 0, 0, 1, 0, 0, 0, 0, 16'd5, 3'd5, 32'h0);
        add(0, 3'd0, 32'h0,         0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd5, 3'd4, 32'h0001_0000);

        // Reset state
        tick(); tick();
        check("rst_core_reset", 64'(core_reset), 64'(1));
        check("rst_h11", 64'(h11), 64'h0001_0000);
        check("rst_h22", 64'(h22), 64'h0001_0000);
        check("rst_h_others", 64'(h12 | h13 | h21 | h23 | h31 | h32), 64'(0));
        check("rst_pend", 64'(commit_pend), 64'(0));
        check("rst_running", 64'(running), 64'(0));
        check("rst_clock_en", 64'(core_clock_en), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        check("rst_vid_tready", 64'(vid_tready), 64'(1));
        $display("reset: core_reset=%0d h11=%0h h22=%0h", core_reset, h11, h22);
        reset = 0;
        count_reset_hold("rsth_hold");
        check("idle_vid_tready", 64'(vid_tready), 64'(1));

        // Table-driven main sequence
        for (int i = 0; i < vecs.size(); i++) begin
            cfg_wr_en = vecs[i].wr_en; cfg_wr_addr = vecs[i].addr; cfg_wr_data = vecs[i].data;
            cfg_commit = vecs[i].commit; enable_req = vecs[i].en;
            vid_tvalid = vecs[i].tvalid; vid_tuser = vecs[i].tuser; core_tready = vecs[i].ctready;
            #1;
            check($sformatf("v%0d_vid_tready", i), 64'(vid_tready), 64'(vecs[i].x_tready));
            check($sformatf("v%0d_core_tvalid", i), 64'(core_tvalid), 64'(vecs[i].x_ctvalid));
            tick();
            check($sformatf("v%0d_pend", i), 64'(commit_pend), 64'(vecs[i].x_pend));
            check($sformatf("v%0d_running", i), 64'(running), 64'(vecs[i].x_run));
            check($sformatf("v%0d_clock_en", i), 64'(core_clock_en), 64'(vecs[i].x_run));
            check($sformatf("v%0d_core_reset", i), 64'(core_reset), 64'(0));
            check($sformatf("v%0d_frame_cnt", i), 64'(frame_cnt), 64'(vecs[i].x_fcnt));
            check($sformatf("v%0d_h%0d", i, vecs[i].x_hidx), 64'(get_h(vecs[i].x_hidx)),
                  64'(vecs[i].x_hval));
            $display("vec %0d: tready=%0d ctvalid=%0d pend=%0d run=%0d fcnt=%0d h[%0d]=%0h",
                     i, vecs[i].x_tready, vecs[i].x_ctvalid, commit_pend, running, frame_cnt,
                     vecs[i].x_hidx, get_h(vecs[i].x_hidx));
        end
        idle_inputs();

        // Software reset during a stall with a commit pending
        enable_req = 1; core_tready = 1;
        tick();                                      // IDLE -> ARMED
        vid_tvalid = 1; vid_tuser = 1;
        tick();                                      // ARMED -> RUN, stall
        check("sr_running", 64'(running), 64'(1));
        check("sr_stall_tready", 64'(vid_tready), 64'(0));
        vid_tvalid = 0; vid_tuser = 0;
        cfg_wr_en = 1; cfg_wr_addr = 3'd3; cfg_wr_data = 32'h0000_0777; cfg_commit = 1;
        tick();
        check("sr_pend_set", 64'(commit_pend), 64'(1));
        check("sr_h21_before", 64'(h21), 64'(0));
        cfg_wr_addr = 3'd4; cfg_wr_data = 32'h0000_0999; cfg_commit = 1;
        vid_tvalid = 1; vid_tuser = 1;
        tick();                                      // swap + recommit, stall
        check("sr_swap_h21", 64'(h21), 64'h0000_0777);
        check("sr_swap_h22", 64'(h22), 64'h0001_0000);
        check("sr_pend_rearmed", 64'(commit_pend), 64'(1));
        check("sr_stall2", 64'(vid_tready), 64'(0));
        check("sr_fcnt6", 64'(frame_cnt), 64'(6));
        $display("pre-swreset: pend=%0d tready=%0d fcnt=%0d h21=%0h", commit_pend, vid_tready,
                 frame_cnt, h21);
        cfg_wr_en = 0; cfg_commit = 0; sw_reset_req = 1;
        tick();
        sw_reset_req = 0; enable_req = 0; vid_tvalid = 0; vid_tuser = 0;
        check("swr_core_reset", 64'(core_reset), 64'(1));
        check("swr_stall_cleared", 64'(vid_tready), 64'(1));
        check("swr_pend", 64'(commit_pend), 64'(0));
        check("swr_fcnt", 64'(frame_cnt), 64'(0));
        check("swr_running", 64'(running), 64'(0));
        check("swr_h21_kept", 64'(h21), 64'h0000_0777);
        check("swr_h22_kept", 64'(h22), 64'h0001_0000);
        check("swr_h31_kept", 64'(h31), 64'hFFFF_0001);
        $display("sw_reset: core_reset=%0d pend=%0d fcnt=%0d h31=%0h", core_reset, commit_pend,
                 frame_cnt, h31);
        count_reset_hold("swr_hold");

        // Shadow bank survived the software reset
        cfg_commit = 1;
        tick();
        cfg_commit = 0;
        check("post_pend", 64'(commit_pend), 64'(1));
        tick();
        check("post_h22_swap", 64'(h22), 64'h0000_0999);
        check("post_pend_clr", 64'(commit_pend), 64'(0));
        $display("post-reset commit: h22=%0h pend=%0d", h22, commit_pend);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
